// File: rtl/rot16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rot16_arbiter
// Purpose  : Two-requester arbiter sharing one 16-bit left-rotate datapath.
//            Right rotates are folded into left rotates. Results return
//            through a one-deep registered buffer with valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rot16_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_amt,
  input  logic        req0_dir,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_amt,
  input  logic        req1_dir,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_id
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_gnt;   // requester granted most recently
  logic [15:0] r_rsp_data;
  logic        r_rsp_id;

  logic        w_can_accept;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_accept;
  logic        w_sel_id;
  logic [15:0] w_sel_data;
  logic [3:0]  w_sel_amt;
  logic        w_sel_dir;
  logic [3:0]  w_eff;
  logic [15:0] w_s1;
  logic [15:0] w_s2;
  logic [15:0] w_s4;
  logic [15:0] w_s8;

  assign rsp_valid    = (r_state == S_FULL);
  assign rsp_data     = r_rsp_data;
  assign rsp_id       = r_rsp_id;
  assign w_can_accept = ~rsp_valid | rsp_ready;

  // Pick a winner: lone requester wins; contested goes by pointer or fixed priority
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if ((FAIR != 0) && (r_last_gnt == 1'b0)) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = 1'b1;
      end
    end else if (req0_valid) begin
      w_gnt0 = 1'b1;
    end else if (req1_valid) begin
      w_gnt1 = 1'b1;
    end
  end

  // Readies are forced low while reset is held so no handshake completes
  assign req0_ready = ~reset & w_can_accept & w_gnt0;
  assign req1_ready = ~reset & w_can_accept & w_gnt1;
  assign w_accept   = req0_ready | req1_ready;

  // Route the granted requester's operands into the shared datapath
  always_comb begin
    w_sel_id   = w_gnt1;
    w_sel_data = w_gnt1 ? req1_data : req0_data;
    w_sel_amt  = w_gnt1 ? req1_amt  : req0_amt;
    w_sel_dir  = w_gnt1 ? req1_dir  : req0_dir;
  end

  // A right rotate by n equals a left rotate by the 4-bit negation of n
  assign w_eff = w_sel_dir ? (4'd0 - w_sel_amt) : w_sel_amt;

  // Barrel rotate left in stages of 1/2/4/8
  always_comb begin
    w_s1 = w_eff[0] ? {w_sel_data[14:0], w_sel_data[15]}    : w_sel_data;
    w_s2 = w_eff[1] ? {w_s1[13:0],       w_s1[15:14]}       : w_s1;
    w_s4 = w_eff[2] ? {w_s2[11:0],       w_s2[15:12]}       : w_s2;
    w_s8 = w_eff[3] ? {w_s4[7:0],        w_s4[15:8]}        : w_s4;
  end

  // Buffer occupancy: load wins over drain so back-to-back results keep valid high
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = S_FULL;
    end else if (rsp_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // State register, output buffer and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_rsp_data <= 16'h0000;
      r_rsp_id   <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rsp_data <= w_s8;
        r_rsp_id   <= w_sel_id;
        r_last_gnt <= w_sel_id;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rot16_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot16_arbiter
// Purpose  : Directed scoreboard bench for rot16_arbiter (round-robin DUT
//            plus a fixed-priority instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rot16_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic        req0_dir, req1_dir;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
  logic [15:0] fp_rsp_data;

  typedef struct {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  rot16_arbiter #(.FAIR(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  rot16_arbiter #(.FAIR(0)) u_dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data), .rsp_id(fp_rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push(input logic id, input logic [15:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every completed output handshake is matched against the scoreboard
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got id=%0d data=%h with no expected entry", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_data", {16'h0, rsp_data}, {16'h0, e.data});
        chk("sb_id", {31'h0, rsp_id}, {31'h0, e.id});
      end
    end
  end

  // Watchdog keeps the run bounded
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Contested round-robin vectors (hand-computed rotations)
  logic [15:0] w0 [3];
  logic [3:0]  a0 [3];
  logic        d0 [3];
  logic [15:0] e0 [3];
  logic [15:0] w1 [3];
  logic [3:0]  a1 [3];
  logic        d1 [3];
  logic [15:0] e1 [3];

  initial begin
    w0 = '{16'h0001, 16'h0010, 16'h1234};
    a0 = '{4'd1, 4'd3, 4'd15};
    d0 = '{1'b0, 1'b0, 1'b1};
    e0 = '{16'h0002, 16'h0080, 16'h2468};
    w1 = '{16'h8000, 16'h00FF, 16'h0F0F};
    a1 = '{4'd1, 4'd8, 4'd4};
    d1 = '{1'b1, 1'b0, 1'b0};
    e1 = '{16'h4000, 16'hFF00, 16'hF0F0};

    reset = 1'b1;
    req0_valid = 1'b0; req0_data = 16'h0; req0_amt = 4'd0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_data = 16'h0; req1_amt = 4'd0; req1_dir = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("reset_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_data", {16'h0, rsp_data}, 32'h0);
    chk("reset_id", {31'h0, rsp_id}, 32'h0);
    tick();
    reset = 1'b0;

    // Requester 0: 8001 rotl 1 -> 0003
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h8001; req0_amt = 4'd1; req0_dir = 1'b0;
    @(negedge clk);
    chk("t1_ready0", {31'h0, req0_ready}, 32'h1);
    chk("t1_ready1", {31'h0, req1_ready}, 32'h0);
    push(1'b0, 16'h0003);
    tick();
    chk("t1_valid", {31'h0, rsp_valid}, 32'h1);
    chk("t1_data", {16'h0, rsp_data}, 32'h0003);

    // Requester 1: 1234 rotr 4 -> 4123
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h1234; req1_amt = 4'd4; req1_dir = 1'b1;
    @(negedge clk);
    chk("t2_ready1", {31'h0, req1_ready}, 32'h1);
    push(1'b1, 16'h4123);
    tick();
    chk("t2_data", {16'h0, rsp_data}, 32'h4123);
    chk("t2_id", {31'h0, rsp_id}, 32'h1);

    // Right rotate by 0 is identity
    req1_data = 16'hF00F; req1_amt = 4'd0; req1_dir = 1'b1;
    @(negedge clk);
    chk("t3_ready1", {31'h0, req1_ready}, 32'h1);
    push(1'b1, 16'hF00F);
    tick();
    chk("t3_data", {16'h0, rsp_data}, 32'hF00F);

    // Backpressure: load ABCD, then stall three cycles
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 16'hABCD; req0_amt = 4'd0; req0_dir = 1'b0;
    @(negedge clk);
    chk("bp_load_ready0", {31'h0, req0_ready}, 32'h1);
    push(1'b0, 16'hABCD);
    tick();
    rsp_ready = 1'b0;
    req0_data = 16'h00F0; req0_amt = 4'd4; req0_dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready0", {31'h0, req0_ready}, 32'h0);
      chk("bp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_data", {16'h0, rsp_data}, 32'hABCD);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready0", {31'h0, req0_ready}, 32'h1);
    push(1'b0, 16'h000F);
    tick();
    chk("bp_new_valid", {31'h0, rsp_valid}, 32'h1);
    chk("bp_new_data", {16'h0, rsp_data}, 32'h000F);

    // Drain with no request pending
    req0_valid = 1'b0;
    tick();
    chk("drain_valid", {31'h0, rsp_valid}, 32'h0);

    // Load a result held under backpressure, then reset asynchronously
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h1111; req0_amt = 4'd0; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h5555; req1_amt = 4'd1; req1_dir = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready0", {31'h0, req0_ready}, 32'h0);
    chk("pre_rst_ready1", {31'h0, req1_ready}, 32'h1);
    tick();
    chk("pre_rst_data", {16'h0, rsp_data}, 32'hAAAA);
    chk("pre_rst_id", {31'h0, rsp_id}, 32'h1);
    #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_data", {16'h0, rsp_data}, 32'h0);
    chk("rst_id", {31'h0, rsp_id}, 32'h0);
    chk("rst_ready0", {31'h0, req0_ready}, 32'h0);
    chk("rst_ready1", {31'h0, req1_ready}, 32'h0);
    tick();
    reset = 1'b0;

    // Contested traffic: round-robin alternates from 0, fixed priority always 0
    for (int k = 0; k < 6; k++) begin
      req0_data = w0[(k + 1) / 2]; req0_amt = a0[(k + 1) / 2]; req0_dir = d0[(k + 1) / 2];
      req1_data = w1[k / 2];       req1_amt = a1[k / 2];       req1_dir = d1[k / 2];
      @(negedge clk);
      chk("rr_ready0", {31'h0, req0_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_ready1", {31'h0, req1_ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("fp_ready0", {31'h0, fp_req0_ready}, 32'h1);
      chk("fp_ready1", {31'h0, fp_req1_ready}, 32'h0);
      if (k % 2 == 0) push(1'b0, e0[(k + 1) / 2]);
      else            push(1'b1, e1[k / 2]);
      tick();
      chk("rr_valid", {31'h0, rsp_valid}, 32'h1);
      chk("rr_id", {31'h0, rsp_id}, (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("fp_id", {31'h0, fp_rsp_id}, 32'h0);
    end

    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    chk("sb_empty", q.size(), 32'h0);
    chk("final_valid", {31'h0, rsp_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rot16_arbiter.md
# rot16_arbiter

Shares a single 16-bit left-rotate datapath between two requesters. Each requester submits a word, a 4-bit rotate amount and a direction. The block arbitrates between them, converts right rotates into the equivalent left rotate, and returns the tagged result through a one-deep registered output buffer with valid/ready backpressure. It sits between requesters (e.g. ALU sequencer and address generator) and the downstream consumer of rotated words.

## Interface
Parameters:
- FAIR, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0's request is accepted this cycle.
- req0_data  in  16  word to rotate.
- req0_amt  in  4  rotate amount, 0..15.
- req0_dir  in  1  0 = rotate left, 1 = rotate right.
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir: same as requester 0, for requester 1.
- rsp_valid  out  1  rsp_data/rsp_id hold a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_data  out  16  rotated word.
- rsp_id  out  1  index of the requester that produced rsp_data.

## Operation
- Two states, tracked by rsp_valid:
  - EMPTY: no result held.
  - FULL: result held.
- can_accept = ~rsp_valid | rsp_ready. It is true in EMPTY, or in FULL when the held result drains this cycle.
- Arbitration happens only when can_accept is true:
  - If exactly one requester is valid, that requester is granted.
  - If both are valid and FAIR=1, the requester not granted most recently wins. The pointer updates only on an actual grant.
  - If both are valid and FAIR=0, requester 0 wins.
- reqN_ready = can_accept & granted(N). At most one ready is high per cycle. No ready is asserted without the matching valid.
- reqN_ready may combinationally depend on both valids and on rsp_ready.
- Requesters must hold valid, data, amt and dir stable until accepted. Requesters must not derive valid from ready.
- Effective left amount:
  - dir=0: eff = amt.
  - dir=1: eff = (16 − amt) mod 16, computed as 4-bit two's-complement negation. amt=0 with dir=1 therefore gives eff=0.
- Result: rsp_data = rotl(data, eff). This is a 4-stage barrel of 1/2/4/8 selected by eff[0..3], with no bits lost.
- On accept: rsp_data, rsp_id and rsp_valid=1 are registered at the edge.
- In FULL with rsp_ready=0: rsp_data and rsp_id are held stable and both readies are 0.
- In FULL with rsp_ready=1 and no request: rsp_valid clears at the edge.
- In FULL with rsp_ready=1 and a request: the held result drains and the new one is loaded at the same edge, so rsp_valid stays 1.

## Timing
- Reset, applied asynchronously and effective immediately:
  - rsp_valid=0, rsp_data=16'h0000, rsp_id=0.
  - Round-robin pointer set so requester 0 wins the first contested grant.
  - req0_ready=req1_ready=0 while reset is high.
- Reset mid-operation discards any held result and any unfinished handshake. There is no partial output.
- Latency: a request accepted at edge N shows rsp_valid=1 with its result immediately after edge N. That is one cycle.
- Throughput: one result per cycle when rsp_ready is held high and requests are available.
- Contested round-robin throughput alternates 0,1,0,1 with no bubble.

## Test plan
- Requester 0 sends 16'h8001, amt=1, dir=0, with rsp_ready=1. One cycle later: rsp_valid=1, rsp_data=16'h0003, rsp_id=0.
- Requester 1 sends 16'h1234, amt=4, dir=1 (eff=12). Expect rsp_data=16'h4123, rsp_id=1. Then send 16'hF00F, amt=0, dir=1 and expect rsp_data=16'hF00F.
- FAIR=1, both requesters valid continuously, rsp_ready=1: grants go 0,1,0,1,… starting with 0 after reset. With FAIR=0 under the same stimulus, all grants go to 0 and requester 1 is never readied.
- Backpressure:
  - Hold a result of 16'hABCD with rsp_ready=0 for 3 cycles while requester 0 is valid. Expect req0_ready=0 and rsp_data stable.
  - Raise rsp_ready. The same cycle, req0_ready=1, and the new result replaces 16'hABCD with no idle cycle.
- Drain without a new request: in FULL, raise rsp_ready with both valids low. rsp_valid goes 0 at the next edge.
- Assert reset asynchronously between edges while rsp_valid=1 and both requesters are valid:
  - rsp_valid, rsp_data and rsp_id go to 0 immediately, and both readies go to 0.
  - After reset releases, the first contested grant goes to requester 0.
